// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: ALU results win over buffered load results,
// with a pending-load scoreboard for hazard queries.
module writeback_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_address,
    input  logic [4:0]  rs2_address,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        en,
    output logic [4:0]  rd,
    output logic [31:0] register_file_data
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [4:0]    fifo_rd_q   [DEPTH];
    logic [4:0]    fifo_rd_d   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pending_q, pending_d;
    logic          en_q, en_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   data_q, data_d;

    logic push, pop;
    logic [4:0] head_rd;

    assign lsu_ready = (count_q != CW'(DEPTH));
    assign push      = lsu_valid & lsu_ready;
    assign pop       = ~alu_valid & (count_q != '0);
    assign head_rd   = fifo_rd_q[rd_ptr_q];

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = lsu_rd;
            fifo_data_d[wr_ptr_q] = lsu_data;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Write-port select; rd/data only hold when nothing was selected.
    always_comb begin
        en_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (alu_valid) begin
            en_d   = (alu_rd != 5'd0);
            rd_d   = alu_rd;
            data_d = alu_data;
        end else if (pop) begin
            en_d   = (head_rd != 5'd0);
            rd_d   = head_rd;
            data_d = fifo_data_q[rd_ptr_q];
        end
    end

    // Clear before set so a same-cycle issue to the popped register wins.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[head_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign rs1_busy = (rs1_address != 5'd0) & pending_q[rs1_address];
    assign rs2_busy = (rs2_address != 5'd0) & pending_q[rs2_address];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            en_q      <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            en_q      <= en_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    // Buffer storage needs no reset: entries are only read below count.
    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    assign en                 = en_q;
    assign rd                 = rd_q;
    assign register_file_data = data_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed table, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_writeback_unit;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_address;
    logic [4:0]  rs2_address;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] register_file_data;

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .alu_valid          (alu_valid),
        .alu_rd             (alu_rd),
        .alu_data           (alu_data),
        .lsu_valid          (lsu_valid),
        .lsu_rd             (lsu_rd),
        .lsu_data           (lsu_data),
        .lsu_ready          (lsu_ready),
        .issue_valid        (issue_valid),
        .issue_rd           (issue_rd),
        .rs1_address        (rs1_address),
        .rs2_address        (rs2_address),
        .rs1_busy           (rs1_busy),
        .rs2_busy           (rs2_busy),
        .en                 (en),
        .rd                 (rd),
        .register_file_data (register_file_data)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    // Reference model state
    entry_t      mq[$];
    bit [31:0]   m_pend;
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0;
        rs1_address = 0; rs2_address = 0;
    endtask

    function automatic bit mbusy(input logic [4:0] a);
        return (a != 0) && m_pend[a];
    endfunction

    // Checks combinational outputs, advances model and DUT one edge, checks registered outputs.
    task automatic step();
        bit     ready_m;
        entry_t e;
        #1;
        ready_m = (mq.size() != DEPTH);
        chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, ready_m});
        chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, mbusy(rs1_address)});
        chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, mbusy(rs2_address)});
        if (!rst_n) begin
            mq.delete();
            m_pend = '0;
            m_en = 0; m_rd = 0; m_data = 0;
        end else begin
            m_en = 0;
            if (alu_valid) begin
                m_en = (alu_rd != 0);
                if (m_en) begin m_rd = alu_rd; m_data = alu_data; end
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_pend[e.rd] = 0;
                m_en = (e.rd != 0);
                if (m_en) begin m_rd = e.rd; m_data = e.data; end
            end
            if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
            if (lsu_valid && ready_m) begin
                e.rd = lsu_rd; e.data = lsu_data;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("en", {31'd0, en}, {31'd0, m_en});
        if (m_en) begin
            chk("rd", {27'd0, rd}, {27'd0, m_rd});
            chk("data", register_file_data, m_data);
        end
    endtask

    typedef struct {
        logic        av; logic [4:0] ard; logic [31:0] adat;
        logic        lv; logic [4:0] lrd; logic [31:0] ldat;
        logic        iv; logic [4:0] ird;
        logic [4:0]  rs1;
        logic        x_ready; logic x_busy;
        logic        x_en; logic [4:0] x_rd; logic [31:0] x_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Directed table: ALU write, load path with hazard, zero register.
        vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 7, 1, 0, 1, 5, 32'hDEADBEEF};
        vecs[1] = '{0, 0, 0,            0, 0, 0,            1, 7, 7, 1, 0, 0, 0, 0};
        vecs[2] = '{0, 0, 0,            1, 7, 32'h12345678, 0, 0, 7, 1, 1, 0, 0, 0};
        vecs[3] = '{0, 0, 0,            0, 0, 0,            0, 0, 7, 1, 1, 1, 7, 32'h12345678};
        vecs[4] = '{0, 0, 0,            0, 0, 0,            0, 0, 7, 1, 0, 0, 0, 0};
        vecs[5] = '{1, 0, 32'h1,        1, 0, 32'h2,        0, 0, 0, 1, 0, 0, 0, 0};
        vecs[6] = '{0, 0, 0,            0, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0};
        vecs[7] = '{0, 0, 0,            0, 0, 0,            0, 0, 0, 1, 0, 0, 0, 0};
        vecs[6].x_ready = 1;

        idle();
        rst_n = 0;
        step();
        chk("reset_en", {31'd0, en}, 32'd0);
        chk("reset_rd", {27'd0, rd}, 32'd0);
        chk("reset_data", register_file_data, 32'd0);
        chk("reset_ready", {31'd0, lsu_ready}, 32'd1);
        rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
            lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ldat;
            issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
            rs1_address = vecs[i].rs1; rs2_address = vecs[i].ird;
            #1;
            chk($sformatf("vec%0d_ready", i), {31'd0, lsu_ready}, {31'd0, vecs[i].x_ready});
            chk($sformatf("vec%0d_busy", i), {31'd0, rs1_busy}, {31'd0, vecs[i].x_busy});
            step();
            chk($sformatf("vec%0d_en", i), {31'd0, en}, {31'd0, vecs[i].x_en});
            if (vecs[i].x_en) begin
                chk($sformatf("vec%0d_rd", i), {27'd0, rd}, {27'd0, vecs[i].x_rd});
                chk($sformatf("vec%0d_data", i), register_file_data, vecs[i].x_data);
            end
        end

        // Priority and full: ALU held 4 cycles while 3 loads are offered.
        for (int c = 0; c < 7; c++) begin
            idle();
            alu_valid = (c < 4); alu_rd = 5'(c + 1); alu_data = 32'hA000_0000 + c;
            lsu_valid = 1'b1;
            lsu_rd    = (c == 0) ? 5'd10 : (c == 1) ? 5'd11 : 5'd12;
            lsu_data  = 32'hB000_0000 + 32'(lsu_rd);
            if (c >= 2) begin
                #1;
                chk("full_ready", {31'd0, lsu_ready}, (c >= 2 && c <= 4) ? 32'd0 : 32'd1);
            end
            if (c == 5) lsu_valid = 1'b1;
            if (c == 6) lsu_valid = 1'b0;
            step();
            if (c >= 4) begin
                chk("full_order_rd", {27'd0, rd}, 32'd10 + 32'(c - 4));
                chk("full_order_data", register_file_data, 32'hB000_000A + 32'(c - 4));
            end else begin
                chk("full_alu_rd", {27'd0, rd}, 32'(c + 1));
            end
        end
        idle(); step();

        // Set/clear collision on x9.
        idle(); issue_valid = 1; issue_rd = 9; step();
        idle(); lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99; step();
        idle(); issue_valid = 1; issue_rd = 9; rs1_address = 9; step();
        chk("collide_en", {31'd0, en}, 32'd1);
        idle(); rs1_address = 9; #1;
        chk("collide_busy", {31'd0, rs1_busy}, 32'd1);
        step();

        // Reset mid-stream with two buffered loads.
        idle(); issue_valid = 1; issue_rd = 3; step();
        idle(); alu_valid = 1; alu_rd = 1; lsu_valid = 1; lsu_rd = 3; step();
        idle(); alu_valid = 1; alu_rd = 2; lsu_valid = 1; lsu_rd = 4; step();
        idle(); alu_valid = 1; alu_rd = 6; lsu_valid = 1; lsu_rd = 8;
        issue_valid = 1; issue_rd = 12; rst_n = 0; step();
        rst_n = 1;
        idle(); rs1_address = 3; rs2_address = 9; #1;
        chk("rst_en", {31'd0, en}, 32'd0);
        chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst_busy1", {31'd0, rs1_busy}, 32'd0);
        chk("rst_busy2", {31'd0, rs2_busy}, 32'd0);
        step();
        chk("rst_nowrite", {31'd0, en}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            alu_valid   = ($urandom_range(0, 99) < 40);
            alu_rd      = 5'($urandom_range(0, 31));
            alu_data    = $urandom;
            lsu_valid   = ($urandom_range(0, 99) < 50);
            lsu_rd      = 5'($urandom_range(0, 7));
            lsu_data    = $urandom;
            issue_valid = ($urandom_range(0, 99) < 30);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1_address = 5'($urandom_range(0, 8));
            rs2_address = 5'($urandom_range(0, 31));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
